// File: rtl/whitening_tx_ctrl_if.sv
// rtl/whitening_tx_ctrl_if.sv - control, FIFO and whitening-side signals of the TX sequencer
interface whitening_tx_ctrl_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] pkt_len;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic             fifo_rd_en;
    logic             fifo_in;
    logic             fifo_in_valid;
    logic             CRC_in;
    logic             CRC_in_valid;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        input  start, pkt_len, fifo_empty, fifo_rdata,
        output fifo_rd_en, fifo_in, fifo_in_valid, CRC_in, CRC_in_valid, busy, done, error
    );

    modport slave (
        output start, pkt_len, fifo_empty, fifo_rdata,
        input  fifo_rd_en, fifo_in, fifo_in_valid, CRC_in, CRC_in_valid, busy, done, error
    );
endinterface

// File: rtl/whitening_tx_ctrl.sv
// rtl/whitening_tx_ctrl.sv - packet TX sequencer: FIFO bytes to LSB-first bits, CRC-24 trailer
// Optional WHT_CTRL_IFS_EN stretches the DONE state to IFS_CYCLES cycles.
module whitening_tx_ctrl #(
    parameter int          LEN_W      = 8,
    parameter logic [23:0] CRC_INIT   = 24'h555555,
    parameter logic [23:0] CRC_POLY   = 24'h00065B,
    parameter int          IFS_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    whitening_tx_ctrl_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DATA,
        S_GAP,
        S_CRC,
        S_DONE
    } state_t;

    localparam int IFS_LEN = (IFS_CYCLES < 1) ? 1 : IFS_CYCLES;
    localparam int IFS_W   = $clog2(IFS_LEN + 1);
`ifdef WHT_CTRL_IFS_EN
    localparam logic [IFS_W-1:0] DONE_LAST = IFS_W'(IFS_LEN - 1);
`else
    localparam logic [IFS_W-1:0] DONE_LAST = '0;
`endif

    state_t           state_q;
    logic [7:0]       shreg_q;
    logic [2:0]       bit_cnt_q;
    logic [LEN_W-1:0] byte_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [23:0]      crc_q;
    logic [23:0]      crc_d;
    logic [4:0]       crc_cnt_q;
    logic [IFS_W-1:0] ifs_cnt_q;
    logic             fifo_in_q;
    logic             fifo_in_valid_q;
    logic             crc_in_q;
    logic             crc_in_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic             rd_en;
    logic             more_bytes;

    assign more_bytes = (byte_cnt_q < len_q);

    // The bit currently on fifo_in is folded into the CRC in the same cycle.
    always_comb begin
        crc_d = {crc_q[22:0], 1'b0};
        if (fifo_in_q ^ crc_q[23]) begin
            crc_d = crc_d ^ CRC_POLY;
        end
    end

    always_comb begin
        rd_en = 1'b0;
        if (state_q == S_LOAD) begin
            rd_en = !bus.fifo_empty;
        end else if (state_q == S_DATA) begin
            rd_en = (bit_cnt_q == 3'd7) && more_bytes && !bus.fifo_empty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            shreg_q         <= '0;
            bit_cnt_q       <= '0;
            byte_cnt_q      <= '0;
            len_q           <= '0;
            crc_q           <= '0;
            crc_cnt_q       <= '0;
            ifs_cnt_q       <= '0;
            fifo_in_q       <= 1'b0;
            fifo_in_valid_q <= 1'b0;
            crc_in_q        <= 1'b0;
            crc_in_valid_q  <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.pkt_len != '0) begin
                            len_q   <= bus.pkt_len;
                            crc_q   <= CRC_INIT;
                            busy_q  <= 1'b1;
                            state_q <= S_LOAD;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (!bus.fifo_empty) begin
                        fifo_in_q       <= bus.fifo_rdata[0];
                        shreg_q         <= {1'b0, bus.fifo_rdata[7:1]};
                        fifo_in_valid_q <= 1'b1;
                        bit_cnt_q       <= '0;
                        byte_cnt_q      <= LEN_W'(1);
                        state_q         <= S_DATA;
                    end
                end
                S_DATA: begin
                    crc_q <= crc_d;
                    if (bit_cnt_q != 3'd7) begin
                        fifo_in_q <= shreg_q[0];
                        shreg_q   <= {1'b0, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end else if (more_bytes) begin
                        if (!bus.fifo_empty) begin
                            // Refill on the last bit so the next byte follows with no bubble.
                            fifo_in_q  <= bus.fifo_rdata[0];
                            shreg_q    <= {1'b0, bus.fifo_rdata[7:1]};
                            bit_cnt_q  <= '0;
                            byte_cnt_q <= byte_cnt_q + LEN_W'(1);
                        end else begin
                            fifo_in_q       <= 1'b0;
                            fifo_in_valid_q <= 1'b0;
                            busy_q          <= 1'b0;
                            error_q         <= 1'b1;
                            state_q         <= S_IDLE;
                        end
                    end else begin
                        fifo_in_q       <= 1'b0;
                        fifo_in_valid_q <= 1'b0;
                        state_q         <= S_GAP;
                    end
                end
                S_GAP: begin
                    crc_in_q       <= crc_q[23];
                    crc_q          <= {crc_q[22:0], 1'b0};
                    crc_cnt_q      <= '0;
                    crc_in_valid_q <= 1'b1;
                    state_q        <= S_CRC;
                end
                S_CRC: begin
                    if (crc_cnt_q == 5'd23) begin
                        crc_in_q       <= 1'b0;
                        crc_in_valid_q <= 1'b0;
                        ifs_cnt_q      <= DONE_LAST;
                        done_q         <= (DONE_LAST == '0);
                        state_q        <= S_DONE;
                    end else begin
                        crc_in_q  <= crc_q[23];
                        crc_q     <= {crc_q[22:0], 1'b0};
                        crc_cnt_q <= crc_cnt_q + 5'd1;
                    end
                end
                S_DONE: begin
                    if (ifs_cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        ifs_cnt_q <= ifs_cnt_q - IFS_W'(1);
                        done_q    <= (ifs_cnt_q == IFS_W'(1));
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fifo_rd_en    = rd_en;
    assign bus.fifo_in       = fifo_in_q;
    assign bus.fifo_in_valid = fifo_in_valid_q;
    assign bus.CRC_in        = crc_in_q;
    assign bus.CRC_in_valid  = crc_in_valid_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.error         = error_q;
endmodule

// File: doc/whitening_tx_ctrl.md
Name: whitening_tx_ctrl

Overview:
- Packet transmit sequencer that drives the serial whitening datapath.
- Pops payload bytes from a show-ahead (first-word-fall-through) byte FIFO and serialises them LSB-first as a gap-free bit stream on the payload channel.
- Computes CRC-24 over the payload bits, then shifts the CRC out on the CRC channel.
- Enforces the inter-phase and inter-packet idle cycles the whitening block needs to keep its bit framing and PN reseed correct.

Parameters:
LEN_W, 8, width of payload length in bytes (valid lengths 1..2^LEN_W-1)
CRC_INIT, 24'h555555, CRC register value loaded at start
CRC_POLY, 24'h00065B, CRC-24 feedback taps (x^24+x^10+x^9+x^6+x^4+x^3+x+1)
IFS_CYCLES, 16, minimum idle cycles after a packet (used only with WHT_CTRL_IFS_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request; sampled only in IDLE
pkt_len  in  LEN_W  payload length in bytes, latched on accepted start
fifo_empty  in  1  byte FIFO empty
fifo_rdata  in  8  FIFO head byte, valid whenever !fifo_empty
fifo_rd_en  out  1  pop FIFO head this cycle
fifo_in  out  1  payload bit to whitening
fifo_in_valid  out  1  payload bit valid
CRC_in  out  1  CRC bit to whitening
CRC_in_valid  out  1  CRC bit valid
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: packet completed
error  out  1  one-cycle pulse: zero length or FIFO underflow

Behaviour:
- Reset (asynchronous, any time, including mid-packet):
  - State IDLE; every output 0.
  - Shift register, counters and CRC register cleared.
  - No done or error pulse is generated by the reset.
- Output timing:
  - fifo_in, fifo_in_valid, CRC_in, CRC_in_valid, busy, done and error come straight from registers.
  - fifo_rd_en is combinational from state, counters and fifo_empty.
- States: IDLE, LOAD, DATA, GAP, CRC, DONE.
- IDLE:
  - start=1 and pkt_len!=0: latch pkt_len, crc <= CRC_INIT, go to LOAD.
  - start=1 and pkt_len==0: pulse error next cycle, stay IDLE.
- LOAD:
  - Waits indefinitely while fifo_empty=1.
  - When !fifo_empty: fifo_rd_en=1, shreg <= fifo_rdata, bit_cnt <= 0, byte_cnt <= 1, go to DATA.
- DATA:
  - fifo_in=shreg[0], fifo_in_valid=1 every cycle, shifting right one bit per cycle.
  - CRC update per bit: fb = fifo_in ^ crc[23]; crc <= {crc[22:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - At bit_cnt==7 with byte_cnt<len: fifo_in_valid stays high with no bubble (refill rule below).
    - If !fifo_empty: fifo_rd_en=1, shreg <= fifo_rdata, byte_cnt++.
    - If fifo_empty (underflow): go to IDLE; valid drops next cycle; error pulse; no CRC, no done.
  - At bit_cnt==7 with byte_cnt==len: go to GAP.
- GAP:
  - Exactly one cycle with both valids low; lets whitening move from payload to CRC phase.
- CRC:
  - CRC_in=crc[23], CRC_in_valid=1, crc shifts left (zero fill).
  - Exactly 24 cycles, then DONE.
- DONE:
  - All valids low; done pulses one cycle; then IDLE.
  - This guarantees at least one idle cycle so whitening reseeds before the next packet.
- start while busy=1 is ignored (not queued).
- Total latency from start cycle t: LOAD at t+1 (FIFO non-empty), payload bits t+2 .. t+1+8N, GAP t+2+8N, CRC t+3+8N .. t+26+8N, done t+27+8N.
- fifo_in_valid and CRC_in_valid are never high in the same cycle.

Optional Feature:
- WHT_CTRL_IFS_EN defined:
  - DONE state lasts IFS_CYCLES cycles (down-counter; IFS_CYCLES=0 is treated as 1).
  - busy stays high throughout; done pulses on the last DONE cycle.
- Not defined: DONE is one cycle as above.

Test Plan:
- CRC_INIT=0, pkt_len=1, FIFO={0x00}, start at t=0 -> fifo_rd_en at t=1; fifo_in_valid t=2..9 all bits 0; GAP t=10; CRC_in_valid t=11..34 all CRC bits 0; done at t=35.
- pkt_len=1, FIFO={0xA5} -> fifo_in at t=2..9 = 1,0,1,0,0,1,0,1; 24 CRC bits match the software CRC-24 model (default CRC_INIT and CRC_POLY).
- pkt_len=3, FIFO={0x11,0x22,0x33} preloaded -> fifo_in_valid continuous for 24 cycles; fifo_rd_en at t=1, t=9, t=17; no bubbles.
- pkt_len=3, FIFO holds only 2 bytes -> fifo_in_valid high 16 cycles then low; error pulse; no CRC_in_valid; no done; busy=0 afterwards.
- pkt_len=0 -> error pulse at t=1, busy stays 0. start while busy -> ignored, only one done.
- rst asserted during CRC phase -> all outputs 0 immediately; a new start after release runs a full correct packet with CRC from CRC_INIT.
